// File: rtl/alu_op_decoder_pkg.sv
// Shared constants and types for the ALU operation decoder: opcodes,
// R-type function fields, ALU function codes and the buffered entry layout.
package alu_op_decoder_pkg;

  localparam int DEF_WORD_SIZE = 16;

  // Primary opcodes (instr[15:12])
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type function field (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALU function codes shared with the execute-stage ALU
  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_ORR     = 4'b0011;
  localparam logic [3:0] ALU_NOT     = 4'b0100;
  localparam logic [3:0] ALU_TCP     = 4'b0101;
  localparam logic [3:0] ALU_SHL     = 4'b0110;
  localparam logic [3:0] ALU_SHR     = 4'b0111;
  localparam logic [3:0] ALU_ADD_IMM = 4'b1000;
  localparam logic [3:0] ALU_ORR_IMM = 4'b1001;
  localparam logic [3:0] ALU_LHI     = 4'b1010;

  // Link register written by JAL / JRL
  localparam logic [1:0] LINK_REG = 2'd2;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // Decoded control fields; the extended immediate is kept alongside
  // because its width follows the datapath parameter.
  typedef struct packed {
    logic [3:0] alu_func;
    logic       alu_b_sel;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] wr_reg;
    logic       wr_en;
    logic       illegal;
  } dec_ctl_t;

endpackage

// File: rtl/alu_op_decode_comb.sv
// Pure combinational instruction-to-fields decoder.
module alu_op_decode_comb
  import alu_op_decoder_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] instr_i,
  output dec_ctl_t             ctl_o,
  output logic [WORD_SIZE-1:0] imm_o
);

  logic [3:0]           opcode_s;
  logic [5:0]           func_s;
  logic [1:0]           rd_s;
  logic [WORD_SIZE-1:0] sext_s;
  logic [WORD_SIZE-1:0] zext_s;

  assign opcode_s = instr_i[15:12];
  assign func_s   = instr_i[5:0];
  assign rd_s     = instr_i[7:6];
  assign sext_s   = {{(WORD_SIZE-8){instr_i[7]}}, instr_i[7:0]};
  assign zext_s   = {{(WORD_SIZE-8){1'b0}}, instr_i[7:0]};

  // Decode opcode/func into ALU control, operand select and write-back fields
  always_comb begin
    ctl_o.alu_func  = ALU_ADD;
    ctl_o.alu_b_sel = 1'b0;
    ctl_o.rs        = instr_i[11:10];
    ctl_o.rt        = instr_i[9:8];
    ctl_o.wr_reg    = 2'd0;
    ctl_o.wr_en     = 1'b0;
    ctl_o.illegal   = 1'b0;
    imm_o           = sext_s;
    case (opcode_s)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
        ctl_o.alu_func = ALU_SUB;
      end
      OP_ADI, OP_LWD: begin
        ctl_o.alu_func  = ALU_ADD_IMM;
        ctl_o.alu_b_sel = 1'b1;
        ctl_o.wr_reg    = instr_i[9:8];
        ctl_o.wr_en     = 1'b1;
      end
      OP_ORI: begin
        ctl_o.alu_func  = ALU_ORR_IMM;
        ctl_o.alu_b_sel = 1'b1;
        ctl_o.wr_reg    = instr_i[9:8];
        ctl_o.wr_en     = 1'b1;
        imm_o           = zext_s;
      end
      OP_LHI: begin
        ctl_o.alu_func  = ALU_LHI;
        ctl_o.alu_b_sel = 1'b1;
        ctl_o.wr_reg    = instr_i[9:8];
        ctl_o.wr_en     = 1'b1;
        imm_o           = zext_s;
      end
      OP_SWD: begin
        ctl_o.alu_func  = ALU_ADD_IMM;
        ctl_o.alu_b_sel = 1'b1;
      end
      OP_JMP: begin
        ctl_o.wr_en = 1'b0;
      end
      OP_JAL: begin
        ctl_o.wr_reg = LINK_REG;
        ctl_o.wr_en  = 1'b1;
      end
      OP_RTYPE: begin
        case (func_s)
          FN_ADD, FN_SUB, FN_AND, FN_ORR,
          FN_NOT, FN_TCP, FN_SHL, FN_SHR: begin
            ctl_o.alu_func = func_s[3:0];
            ctl_o.wr_reg   = rd_s;
            ctl_o.wr_en    = 1'b1;
          end
          FN_JPR, FN_WWD, FN_HLT: begin
            ctl_o.wr_en = 1'b0;
          end
          FN_JRL: begin
            ctl_o.wr_reg = LINK_REG;
            ctl_o.wr_en  = 1'b1;
          end
          default: begin
            ctl_o.illegal = 1'b1;
          end
        endcase
      end
      default: begin
        ctl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Decode stage: combinational decode feeding a 2-entry skid buffer with
// valid/ready on both sides and a flush for branch/jump redirects.
module alu_op_decoder
  import alu_op_decoder_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_instr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           alu_func,
  output logic                 alu_b_sel,
  output logic [WORD_SIZE-1:0] imm_out,
  output logic [1:0]           rs_out,
  output logic [1:0]           rt_out,
  output logic [1:0]           wr_reg,
  output logic                 wr_en,
  output logic                 illegal
);

  buf_state_e           state_q, state_d;
  logic                 in_ready_q;
  logic                 out_valid_q;
  dec_ctl_t             head_ctl_q, head_ctl_d;
  dec_ctl_t             tail_ctl_q, tail_ctl_d;
  logic [WORD_SIZE-1:0] head_imm_q, head_imm_d;
  logic [WORD_SIZE-1:0] tail_imm_q, tail_imm_d;
  dec_ctl_t             dec_ctl_s;
  logic [WORD_SIZE-1:0] dec_imm_s;
  logic                 push_s;
  logic                 pop_s;

  alu_op_decode_comb #(.WORD_SIZE(WORD_SIZE)) u_decode (
    .instr_i (in_instr),
    .ctl_o   (dec_ctl_s),
    .imm_o   (dec_imm_s)
  );

  assign push_s = in_valid && in_ready_q;
  assign pop_s  = out_valid_q && out_ready;

  // State register; ready/valid are registered from the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != BUF_FULL);
      out_valid_q <= (state_d != BUF_EMPTY);
    end
  end

  // Next-state logic; flush dominates any push/pop in the same cycle
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push_s) state_d = BUF_ONE;
          else        state_d = BUF_EMPTY;
        end
        BUF_ONE: begin
          if (push_s && !pop_s)      state_d = BUF_FULL;
          else if (!push_s && pop_s) state_d = BUF_EMPTY;
          else                       state_d = BUF_ONE;
        end
        BUF_FULL: begin
          if (pop_s) state_d = BUF_ONE;
          else       state_d = BUF_FULL;
        end
        default: begin
          state_d = BUF_EMPTY;
        end
      endcase
    end
  end

  // Entry steering: new decode lands at head or tail, tail promotes on pop
  always_comb begin
    head_ctl_d = head_ctl_q;
    head_imm_d = head_imm_q;
    tail_ctl_d = tail_ctl_q;
    tail_imm_d = tail_imm_q;
    if (flush) begin
      head_ctl_d = head_ctl_q;
      tail_ctl_d = tail_ctl_q;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push_s) begin
            head_ctl_d = dec_ctl_s;
            head_imm_d = dec_imm_s;
          end else begin
            head_ctl_d = head_ctl_q;
          end
        end
        BUF_ONE: begin
          if (push_s && pop_s) begin
            head_ctl_d = dec_ctl_s;
            head_imm_d = dec_imm_s;
          end else if (push_s) begin
            tail_ctl_d = dec_ctl_s;
            tail_imm_d = dec_imm_s;
          end else begin
            head_ctl_d = head_ctl_q;
          end
        end
        BUF_FULL: begin
          if (pop_s) begin
            head_ctl_d = tail_ctl_q;
            head_imm_d = tail_imm_q;
          end else begin
            head_ctl_d = head_ctl_q;
          end
        end
        default: begin
          head_ctl_d = head_ctl_q;
        end
      endcase
    end
  end

  // Entry storage; reset clears the head so all outputs read zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_ctl_q <= '0;
      head_imm_q <= '0;
      tail_ctl_q <= '0;
      tail_imm_q <= '0;
    end else begin
      head_ctl_q <= head_ctl_d;
      head_imm_q <= head_imm_d;
      tail_ctl_q <= tail_ctl_d;
      tail_imm_q <= tail_imm_d;
    end
  end

  // Outputs are driven straight from registers
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    alu_func  = head_ctl_q.alu_func;
    alu_b_sel = head_ctl_q.alu_b_sel;
    imm_out   = head_imm_q;
    rs_out    = head_ctl_q.rs;
    rt_out    = head_ctl_q.rt;
    wr_reg    = head_ctl_q.wr_reg;
    wr_en     = head_ctl_q.wr_en;
    illegal   = head_ctl_q.illegal;
  end

endmodule
